// File: rtl/mario_snd_pkg.sv
// Shared types and constants for the Mario sound-command scheduler.
package mario_snd_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_ACK = 2'd1,
        S_HOLDOFF  = 2'd2
    } snd_state_e;

    localparam int SND_CTRL_IRQ_BIT  = 0;
    localparam int SND_CTRL_TRIG_LSB = 1;

    localparam int DEF_DEPTH       = 8;
    localparam int DEF_HOLDOFF     = 48;
    localparam int DEF_IRQ_TIMEOUT = 4800000;

endpackage

// File: rtl/mario_snd_cmd_fifo.sv
// DEPTH x 8 command FIFO with flush; push and pop together at full is legal.
module mario_snd_cmd_fifo #(
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [7:0]    data_i,
    input  logic          pop_i,
    output logic [7:0]    head_o,
    output logic [AW:0]   level_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q;
    logic          do_push, do_pop;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign head_o  = mem_q[rd_ptr_q];

    // The pop frees the head slot in the same cycle, so a push at full still fits.
    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/mario_sound_cmd_sched.sv
// Sound-command scheduler: queues main-CPU bytes and hands them to the sound sub-CPU
// one at a time via IRQ/ack. Optional ack timeout under MARIO_SND_CMD_TIMEOUT_EN.
module mario_sound_cmd_sched
    import mario_snd_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int HOLDOFF     = DEF_HOLDOFF,
    parameter int IRQ_TIMEOUT = DEF_IRQ_TIMEOUT
) (
    input  logic                      I_CLK_48M,
    input  logic                      I_RSTn,
    input  logic                      I_CMD_WR,
    input  logic [7:0]                I_CMD_DATA,
    input  logic                      I_TRIG_WR,
    input  logic [5:0]                I_TRIG_DATA,
    input  logic                      I_FLUSH,
    input  logic                      I_OVF_CLR,
    input  logic                      I_SUB_RDn,
    input  logic                      I_SUB_SEL,
    output logic [7:0]                O_SND_DATA,
    output logic [6:0]                O_SND_CTRL,
    output logic [$clog2(DEPTH):0]    O_LEVEL,
    output logic                      O_BUSY,
    output logic                      O_OVERFLOW,
    output logic                      O_TIMEOUT
);

    localparam int CNT_W = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    snd_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             irq_q, irq_d;
    logic [7:0]       data_q, data_d;
    logic [5:0]       trig_q;
    logic             rdn_q, ack, pop, rel, ovf_q, ovf_set, to_set;
    logic [7:0]       fifo_head;
    logic             fifo_full, fifo_empty;

    mario_snd_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (I_CLK_48M),
        .rst_n_i (I_RSTn),
        .flush_i (I_FLUSH),
        .push_i  (I_CMD_WR),
        .data_i  (I_CMD_DATA),
        .pop_i   (pop),
        .head_o  (fifo_head),
        .level_o (O_LEVEL),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign ack     = I_SUB_SEL & I_SUB_RDn & ~rdn_q;
    assign ovf_set = I_CMD_WR & ~I_FLUSH & fifo_full & ~pop;

`ifdef MARIO_SND_CMD_TIMEOUT_EN
    localparam int TO_W = $clog2(IRQ_TIMEOUT + 1);
    logic [TO_W-1:0] tcnt_q, tcnt_d;
    logic            to_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        irq_d   = irq_q;
        data_d  = data_q;
        pop     = 1'b0;
        rel     = 1'b0;
        to_set  = 1'b0;
`ifdef MARIO_SND_CMD_TIMEOUT_EN
        tcnt_d  = tcnt_q;
`endif
        if (I_FLUSH) begin
            state_d = S_IDLE;
            irq_d   = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        data_d  = fifo_head;
                        irq_d   = 1'b1;
                        state_d = S_WAIT_ACK;
`ifdef MARIO_SND_CMD_TIMEOUT_EN
                        tcnt_d  = '0;
`endif
                    end
                end
                S_WAIT_ACK: begin
                    rel = ack;
`ifdef MARIO_SND_CMD_TIMEOUT_EN
                    tcnt_d = tcnt_q + TO_W'(1);
                    // Ack in the timeout cycle wins and leaves the flag alone.
                    if (!ack && tcnt_q == TO_W'(IRQ_TIMEOUT - 1)) begin
                        rel    = 1'b1;
                        to_set = 1'b1;
                    end
`endif
                    if (rel) begin
                        irq_d = 1'b0;
                        if (HOLDOFF == 0) begin
                            state_d = S_IDLE;
                        end else begin
                            cnt_d   = CNT_W'(HOLDOFF - 1);
                            state_d = S_HOLDOFF;
                        end
                    end
                end
                S_HOLDOFF: begin
                    if (cnt_q == '0) state_d = S_IDLE;
                    else             cnt_d   = cnt_q - CNT_W'(1);
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge I_CLK_48M or negedge I_RSTn) begin
        if (!I_RSTn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            irq_q   <= 1'b0;
            data_q  <= '0;
            trig_q  <= '0;
            rdn_q   <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            irq_q   <= irq_d;
            data_q  <= data_d;
            rdn_q   <= I_SUB_RDn;
            if (I_TRIG_WR) trig_q <= I_TRIG_DATA;
            if (ovf_set)        ovf_q <= 1'b1;
            else if (I_OVF_CLR) ovf_q <= 1'b0;
        end
    end

`ifdef MARIO_SND_CMD_TIMEOUT_EN
    always_ff @(posedge I_CLK_48M or negedge I_RSTn) begin
        if (!I_RSTn) begin
            tcnt_q <= '0;
            to_q   <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            if (to_set)         to_q <= 1'b1;
            else if (I_OVF_CLR) to_q <= 1'b0;
        end
    end
    assign O_TIMEOUT = to_q;
`else
    assign O_TIMEOUT = 1'b0;
`endif

    assign O_SND_DATA                             = data_q;
    assign O_SND_CTRL[SND_CTRL_IRQ_BIT]           = irq_q;
    assign O_SND_CTRL[SND_CTRL_TRIG_LSB +: 6]     = trig_q;
    assign O_BUSY                                 = (state_q != S_IDLE) | ~fifo_empty;
    assign O_OVERFLOW                             = ovf_q;

endmodule

// File: tb/tb_mario_sound_cmd_sched.sv
// Scoreboard bench for mario_sound_cmd_sched (DEPTH=8, HOLDOFF=4, IRQ_TIMEOUT=16).
module tb_mario_sound_cmd_sched;

    localparam int DEPTH       = 8;
    localparam int HOLDOFF     = 4;
    localparam int IRQ_TIMEOUT = 16;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       cmd_wr = 1'b0, trig_wr = 1'b0, flush = 1'b0, ovf_clr = 1'b0;
    logic       sub_rdn = 1'b1, sub_sel = 1'b0;
    logic [7:0] cmd_data = '0;
    logic [5:0] trig_data = '0;
    logic [7:0] snd_data;
    logic [6:0] snd_ctrl;
    logic [3:0] level;
    logic       busy, ovf, tmo;

    int         checks = 0, failures = 0;
    logic [7:0] sb[$];
    logic [7:0] exp_byte;
    logic       irq_prev = 1'b0;
    wire        irq = snd_ctrl[0];

    mario_sound_cmd_sched #(.DEPTH(DEPTH), .HOLDOFF(HOLDOFF), .IRQ_TIMEOUT(IRQ_TIMEOUT)) dut (
        .I_CLK_48M   (clk),
        .I_RSTn      (rst_n),
        .I_CMD_WR    (cmd_wr),
        .I_CMD_DATA  (cmd_data),
        .I_TRIG_WR   (trig_wr),
        .I_TRIG_DATA (trig_data),
        .I_FLUSH     (flush),
        .I_OVF_CLR   (ovf_clr),
        .I_SUB_RDn   (sub_rdn),
        .I_SUB_SEL   (sub_sel),
        .O_SND_DATA  (snd_data),
        .O_SND_CTRL  (snd_ctrl),
        .O_LEVEL     (level),
        .O_BUSY      (busy),
        .O_OVERFLOW  (ovf),
        .O_TIMEOUT   (tmo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic accepted);
        cmd_wr   = 1'b1;
        cmd_data = d;
        if (accepted) sb.push_back(d);
        tick();
        cmd_wr = 1'b0;
    endtask

    task automatic ack();
        sub_sel = 1'b1;
        sub_rdn = 1'b0;
        tick();
        sub_rdn = 1'b1;
        tick();
        sub_sel = 1'b0;
    endtask

    task automatic wait_irq(input logic val, input int max, input string name, output int n);
        n = 0;
        while (irq !== val && n < max) begin
            tick();
            n++;
        end
        if (irq !== val) begin
            checks++;
            failures++;
            $display("FAIL %s: wait expired, irq=%0b required=%0b", name, irq, val);
        end
    endtask

    task automatic wait_busy_low(output int n);
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
    endtask

    // Monitor: every IRQ rise must present the oldest byte still owed.
    always @(negedge clk) begin
        if (irq === 1'b1 && irq_prev !== 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: byte=%0h presented, none expected", snd_data);
            end else begin
                exp_byte = sb.pop_front();
                check("sb_data", {24'd0, snd_data}, {24'd0, exp_byte});
            end
        end
        irq_prev = irq;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", snd_data, 0);
        check("rst_ctrl", snd_ctrl, 0);
        check("rst_level", level, 0);
        check("rst_busy", busy, 0);
        check("rst_ovf", ovf, 0);
        check("rst_tmo", tmo, 0);
        rst_n = 1'b1;
        tick();

        // single command
        push(8'h1A, 1'b1);
        check("single_irq_N", irq, 0);
        check("single_level_push", level, 1);
        tick();
        check("single_irq_N1", irq, 1);
        check("single_level_pop", level, 0);
        ack();
        check("single_irq_ack", irq, 0);
        push(8'h1B, 1'b1);
        wait_irq(1'b1, 20, "single_next", n);
        check("single_gap", n + 1, HOLDOFF + 1);
        ack();
        wait_busy_low(n);
        check("single_busy_fall", n, HOLDOFF);

        // burst in order
        for (int i = 1; i <= 5; i++) push(8'(i), 1'b1);
        for (int i = 0; i < 5; i++) begin
            wait_irq(1'b1, 20, "burst_irq", n);
            if (i > 0) check("burst_gap", n, HOLDOFF + 1);
            ack();
        end
        wait_busy_low(n);
        check("burst_busy_fall", n, HOLDOFF);
        check("burst_level", level, 0);

        // ack qualification
        push(8'h33, 1'b1);
        wait_irq(1'b1, 20, "qual_irq", n);
        sub_sel = 1'b0;
        sub_rdn = 1'b0;
        tick();
        sub_rdn = 1'b1;
        tick();
        tick();
        check("qual_sel0_irq", irq, 1);
        ack();
        check("qual_ack_irq", irq, 0);
        wait_busy_low(n);
        sub_sel = 1'b1;
        sub_rdn = 1'b0;
        tick();
        sub_rdn = 1'b1;
        tick();
        sub_sel = 1'b0;
        tick();
        check("qual_idle_busy", busy, 0);
        check("qual_idle_irq", irq, 0);
        check("qual_idle_data", snd_data, 8'h33);

        // overflow: 9 pushes with one popped -> full, 9th accepted
        for (int i = 0; i < 9; i++) push(8'(8'h40 + i), 1'b1);
        check("ovf_level_full", level, 8);
        check("ovf_none_yet", ovf, 0);
        push(8'h49, 1'b0);
        push(8'h4A, 1'b0);
        check("ovf_set", ovf, 1);
        check("ovf_level_held", level, 8);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr", ovf, 0);
        ovf_clr = 1'b1;
        push(8'h4B, 1'b0);
        ovf_clr = 1'b0;
        check("ovf_set_wins", ovf, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_clr2", ovf, 0);
        ack();
        repeat (HOLDOFF) tick();
        push(8'h4C, 1'b1);
        check("pushpop_irq", irq, 1);
        check("pushpop_level", level, 8);
        check("pushpop_no_ovf", ovf, 0);

        // flush mid-WAIT_ACK
        trig_wr   = 1'b1;
        trig_data = 6'h2A;
        tick();
        trig_wr = 1'b0;
        check("trig_latch", snd_ctrl[6:1], 6'h2A);
        flush    = 1'b1;
        cmd_wr   = 1'b1;
        cmd_data = 8'h99;
        tick();
        flush  = 1'b0;
        cmd_wr = 1'b0;
        sb.delete();
        check("flush_irq", irq, 0);
        check("flush_level", level, 0);
        check("flush_data", snd_data, 8'h41);
        check("flush_trig", snd_ctrl[6:1], 6'h2A);
        check("flush_busy", busy, 0);

        // async reset mid-HOLDOFF
        push(8'h77, 1'b1);
        wait_irq(1'b1, 20, "rst_irq", n);
        ack();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_data", snd_data, 0);
        check("arst_ctrl", snd_ctrl, 0);
        check("arst_busy", busy, 0);
        check("arst_level", level, 0);
        tick();
        rst_n = 1'b1;
        tick();

`ifdef MARIO_SND_CMD_TIMEOUT_EN
        push(8'h5A, 1'b1);
        push(8'h5B, 1'b1);
        wait_irq(1'b1, 20, "to_irq", n);
        wait_irq(1'b0, 40, "to_fall", n);
        check("to_len", n, IRQ_TIMEOUT);
        check("to_flag", tmo, 1);
        wait_irq(1'b1, 20, "to_next", n);
        check("to_gap", n, HOLDOFF + 1);
        ack();
        wait_busy_low(n);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("to_clr", tmo, 0);
`else
        push(8'h5A, 1'b1);
        wait_irq(1'b1, 20, "noto_irq", n);
        repeat (1000) tick();
        check("noto_irq_held", irq, 1);
        check("noto_flag", tmo, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
`endif
        tick();
        check("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
